rob_commit: RTL and testbench
=============================

# rob_commit

Reorder buffer with in-order retirement; it is the producer side of the commit bus that instruction decode consumes. It allocates one entry per decoded instruction and captures results from the common data bus. It retires the oldest completed entry each cycle, driving register-file writeback and register-status release. On a mispredicted branch it restores the register-status snapshot and broadcasts a pipeline flush.

## Interface
Parameters:
- WIDTH, 31, data MSB (32-bit datapath)
- REG, 4, register index MSB
- ROB, 2, ROB tag MSB (2^(ROB+1) = 8 entries)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- allocReq  in  1  decode requests an entry
- allocRegWrite, allocBranch  in  1 each  entry writes rd / entry is a control-flow op
- allocDestReg  in  REG+1  destination register
- allocStatusSnap  in  WIDTH+1  register-status busy snapshot captured at decode
- allocROB  out  ROB+1  tag granted (the current tail)
- fullRob  out  1  no free entry
- cdbValid  in  1  result broadcast
- cdbROB  in  ROB+1  producing tag
- cdbResult, cdbTarget  in  WIDTH+1 each  result / resolved branch target
- cdbMispredict  in  1  branch resolved wrong
- rob1, rob2  in  ROB+1 each  operand lookup tags
- ready1, ready2  out  1 each  looked-up entry has its result
- value1, value2  out  WIDTH+1 each  looked-up result
- validCommit  out  1  an entry retired this cycle
- commitInfo  out  WIDTH+5+1  [4:0] destination register, [WIDTH+4] regWrite, rest zero
- commitROB  out  ROB+1  retiring tag
- result  out  WIDTH+1  retiring value
- regStatusC  out  WIDTH+1  snapshot to restore
- controlFlow  out  2  [0] flush, [1] redirect valid
- redirectPC  out  WIDTH+1  fetch redirect target

## Operation
- Storage per entry:
  - busy, done, regWrite, branch, mispredict
  - destReg, value, target, statusSnap
- Pointers:
  - head and tail are ROB+1 bits and wrap naturally.
  - count is ROB+2 bits.
  - fullRob = (count == 8).
- Allocate:
  - Allowed when allocReq, not full, and state RUN.
  - Write the entry at tail with busy=1, done=0, then tail++.
  - allocROB = tail combinationally.
  - allocReq while full or while in FLUSH is ignored.
- CDB capture:
  - Applies when cdbValid and entry[cdbROB].busy.
  - Sets done=1 and latches value, target, mispredict.
  - A capture for a non-busy entry is ignored.
- Commit (state RUN):
  - Condition: entry[head].busy and entry[head].done.
  - Registered outputs: validCommit=1, commitInfo, result, commitROB.
  - Clear busy, then head++.
- Mispredict commit:
  - The entry still commits its regWrite (link register).
  - Next-state FLUSH; latch redirectPC = target and regStatusC = statusSnap.
- FSM:
  - RUN -> FLUSH on mispredict commit.
  - FLUSH -> RUN unconditionally after one cycle.
  - In FLUSH: controlFlow = 2'b11; all busy bits cleared; head = tail = count = 0; CDB and allocation ignored.
- Count:
  - Increments on allocation alone.
  - Decrements on commit alone.
  - Unchanged when both occur in the same cycle.
- Lookup: ready/value for robN come combinationally from entry storage; a non-busy entry reads ready=0.

## Timing
- Reset values: all outputs 0, state RUN, head = tail = count = 0, all busy bits 0. A reset mid-flush wins.
- Allocation: the tag is visible the same cycle; the entry is occupied from the next edge.
- Commit latency:
  - CDB write at edge N makes done=1 at N.
  - Commit outputs are registered at N+1 and held exactly one cycle.
- validCommit is a one-cycle pulse per retirement; at most one retirement per cycle.
- Flush pulse: controlFlow[0] is high for exactly the one cycle after the mispredicted commit's outputs. regStatusC and redirectPC are valid in that same cycle.
- CDB write to the head entry and commit in the same cycle: the commit is not allowed; the entry commits on the following cycle.
- Wrap-around: tail 7 -> 0 and head 7 -> 0 with no special casing.

## Configuration
- ROB_CDB_BYPASS_EN defined: a lookup matching cdbROB while cdbValid returns ready=1 and value=cdbResult in the same cycle.
- Undefined: lookup sees the CDB result only after it is stored (one cycle later).

## Structure
- Shared package rob_pkg holds:
  - the rob_entry_t struct
  - the commit_state_t enum {RUN, FLUSH}
  - constant ROB_DEPTH = 8
- One sub-module, rob_lookup: a two-port combinational read with the optional bypass.
- Entry storage, pointers and FSM live in rob_commit.

## Test plan
- Fill: eight allocations -> allocROB 0..7, fullRob=1 after the eighth; a ninth allocReq is ignored and tail stays 0.
- Completion: CDB tag 0 with value 0x55, entry regWrite to x5 -> next cycle validCommit=1, commitInfo[4:0]=5, commitInfo[WIDTH+4]=1, result=0x55.
- Ordering: complete tag 1 before tag 0 -> no commit until tag 0 completes; then tags 0 and 1 retire on consecutive cycles.
- Mispredict: entry 2 is a branch with snapshot 0x0000_00F0, CDB mispredict target 0x100 -> commit of tag 2, then one cycle with controlFlow=2'b11, redirectPC=0x100, regStatusC=0xF0; afterwards count=0 and allocROB=0.
- Simultaneous: allocate and commit in the same cycle while count=4 -> count stays 4 and head and tail both advance.
- Bypass (macro on): cdbValid with tag 3, value 0xAB, and rob1=3 -> ready1=1, value1=0xAB in the same cycle. With the macro off, ready1=0 until the next cycle.

Source files
------------

// File: rtl/rob_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_pkg                                                          |
// | Shared types and constants for the reorder buffer commit block.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package rob_pkg;

  localparam int ROB_DEPTH = 8;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } commit_state_t;

  // Per-entry control flags; the wide payload fields live in separate arrays
  // so they can follow the module's WIDTH/REG parameters.
  typedef struct packed {
    logic busy;
    logic done;
    logic reg_write;
    logic branch;
    logic mispredict;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_lookup.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_lookup                                                       |
// | Two-port combinational operand lookup into ROB entry storage.    |
// | Optional same-cycle CDB bypass when ROB_CDB_BYPASS_EN is defined.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rob_lookup
  import rob_pkg::*;
#(
  parameter  int WIDTH = 31,
  parameter  int ROB   = 2,
  localparam int DEPTH = 1 << (ROB + 1)
) (
  input  logic [DEPTH-1:0] ready_i,
  input  logic [WIDTH:0]   value_i [DEPTH],
  input  logic             cdb_valid_i,
  input  logic [ROB:0]     cdb_rob_i,
  input  logic [WIDTH:0]   cdb_result_i,
  input  logic [ROB:0]     rob1_i,
  input  logic [ROB:0]     rob2_i,
  output logic             ready1_o,
  output logic             ready2_o,
  output logic [WIDTH:0]   value1_o,
  output logic [WIDTH:0]   value2_o
);

  logic [ROB:0]   w_tag [2];
  logic           w_rdy [2];
  logic [WIDTH:0] w_val [2];

  assign w_tag[0] = rob1_i;
  assign w_tag[1] = rob2_i;

  for (genvar p = 0; p < 2; p++) begin : g_port
`ifdef ROB_CDB_BYPASS_EN
    logic w_hit;
    assign w_hit    = cdb_valid_i && (cdb_rob_i == w_tag[p]);
    assign w_rdy[p] = w_hit | ready_i[w_tag[p]];
    assign w_val[p] = w_hit ? cdb_result_i : value_i[w_tag[p]];
`else
    assign w_rdy[p] = ready_i[w_tag[p]];
    assign w_val[p] = value_i[w_tag[p]];
`endif
  end

`ifndef ROB_CDB_BYPASS_EN
  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid_i, cdb_rob_i, cdb_result_i};
`endif

  assign ready1_o = w_rdy[0];
  assign ready2_o = w_rdy[1];
  assign value1_o = w_val[0];
  assign value2_o = w_val[1];

endmodule
`default_nettype wire

// File: rtl/rob_commit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_commit                                                       |
// | Reorder buffer: allocation, CDB capture, in-order retirement and |
// | mispredict flush. Build option: ROB_CDB_BYPASS_EN (lookup bypass)|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rob_commit
  import rob_pkg::*;
#(
  parameter int WIDTH = 31,
  parameter int REG   = 4,
  parameter int ROB   = $clog2(ROB_DEPTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             allocReq,
  input  logic             allocRegWrite,
  input  logic             allocBranch,
  input  logic [REG:0]     allocDestReg,
  input  logic [WIDTH:0]   allocStatusSnap,
  output logic [ROB:0]     allocROB,
  output logic             fullRob,
  input  logic             cdbValid,
  input  logic [ROB:0]     cdbROB,
  input  logic [WIDTH:0]   cdbResult,
  input  logic [WIDTH:0]   cdbTarget,
  input  logic             cdbMispredict,
  input  logic [ROB:0]     rob1,
  input  logic [ROB:0]     rob2,
  output logic             ready1,
  output logic             ready2,
  output logic [WIDTH:0]   value1,
  output logic [WIDTH:0]   value2,
  output logic             validCommit,
  output logic [WIDTH+5:0] commitInfo,
  output logic [ROB:0]     commitROB,
  output logic [WIDTH:0]   result,
  output logic [WIDTH:0]   regStatusC,
  output logic [1:0]       controlFlow,
  output logic [WIDTH:0]   redirectPC
);

  localparam int DEPTH = 1 << (ROB + 1);

  commit_state_t  state_q, state_d;
  rob_entry_t     ent_q    [DEPTH];
  rob_entry_t     ent_d    [DEPTH];
  logic [REG:0]   dest_q   [DEPTH];
  logic [REG:0]   dest_d   [DEPTH];
  logic [WIDTH:0] value_q  [DEPTH];
  logic [WIDTH:0] value_d  [DEPTH];
  logic [WIDTH:0] target_q [DEPTH];
  logic [WIDTH:0] target_d [DEPTH];
  logic [WIDTH:0] snap_q   [DEPTH];
  logic [WIDTH:0] snap_d   [DEPTH];

  logic [ROB:0]   head_q, head_d;
  logic [ROB:0]   tail_q, tail_d;
  logic [ROB+1:0] count_q, count_d;

  logic             valid_commit_q, valid_commit_d;
  logic [WIDTH+5:0] commit_info_q, commit_info_d;
  logic [ROB:0]     commit_rob_q, commit_rob_d;
  logic [WIDTH:0]   result_q, result_d;
  logic [WIDTH:0]   reg_status_q, reg_status_d;
  logic [WIDTH:0]   redirect_q, redirect_d;
  logic [1:0]       ctrl_flow_q, ctrl_flow_d;

  logic             w_full;
  logic             do_alloc;
  logic             do_commit;
  logic [DEPTH-1:0] w_ready;

  // count never exceeds DEPTH, so its MSB alone marks a full buffer
  assign w_full = count_q[ROB+1];

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = ent_q[i].busy & ent_q[i].done;
    end
  end

  always_comb begin
    state_d        = state_q;
    ent_d          = ent_q;
    dest_d         = dest_q;
    value_d        = value_q;
    target_d       = target_q;
    snap_d         = snap_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    valid_commit_d = 1'b0;
    commit_info_d  = '0;
    commit_rob_d   = '0;
    result_d       = '0;
    reg_status_d   = reg_status_q;
    redirect_d     = redirect_q;
    ctrl_flow_d    = 2'b00;
    do_alloc       = 1'b0;
    do_commit      = 1'b0;

    case (state_q)
      FLUSH: begin
        for (int i = 0; i < DEPTH; i++) begin
          ent_d[i].busy = 1'b0;
        end
        head_d      = '0;
        tail_d      = '0;
        count_d     = '0;
        ctrl_flow_d = 2'b11;
        state_d     = RUN;
      end
      default: begin
        do_alloc  = allocReq && !w_full;
        // done comes from storage, so a same-cycle CDB write cannot retire yet
        do_commit = ent_q[head_q].busy && ent_q[head_q].done;

        if (cdbValid && ent_q[cdbROB].busy) begin
          ent_d[cdbROB].done       = 1'b1;
          ent_d[cdbROB].mispredict = cdbMispredict;
          value_d[cdbROB]          = cdbResult;
          target_d[cdbROB]         = cdbTarget;
        end

        if (do_commit) begin
          ent_d[head_q].busy          = 1'b0;
          head_d                      = head_q + 1'b1;
          valid_commit_d              = 1'b1;
          commit_info_d[REG:0]        = dest_q[head_q];
          commit_info_d[WIDTH+4]      = ent_q[head_q].reg_write;
          commit_rob_d                = head_q;
          result_d                    = value_q[head_q];
          if (ent_q[head_q].branch && ent_q[head_q].mispredict) begin
            state_d      = FLUSH;
            redirect_d   = target_q[head_q];
            reg_status_d = snap_q[head_q];
          end
        end

        if (do_alloc) begin
          ent_d[tail_q] = '{busy: 1'b1, done: 1'b0, reg_write: allocRegWrite,
                            branch: allocBranch, mispredict: 1'b0};
          dest_d[tail_q] = allocDestReg;
          snap_d[tail_q] = allocStatusSnap;
          tail_d         = tail_q + 1'b1;
        end

        case ({do_alloc, do_commit})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_commit_q <= 1'b0;
      commit_info_q  <= '0;
      commit_rob_q   <= '0;
      result_q       <= '0;
      reg_status_q   <= '0;
      redirect_q     <= '0;
      ctrl_flow_q    <= 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      ent_q          <= ent_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_commit_q <= valid_commit_d;
      commit_info_q  <= commit_info_d;
      commit_rob_q   <= commit_rob_d;
      result_q       <= result_d;
      reg_status_q   <= reg_status_d;
      redirect_q     <= redirect_d;
      ctrl_flow_q    <= ctrl_flow_d;
    end
  end

  // Payload is qualified by the busy/done flags and needs no reset
  always_ff @(posedge clk) begin
    dest_q   <= dest_d;
    value_q  <= value_d;
    target_q <= target_d;
    snap_q   <= snap_d;
  end

  rob_lookup #(
    .WIDTH (WIDTH),
    .ROB   (ROB)
  ) u_lookup (
    .ready_i      (w_ready),
    .value_i      (value_q),
    .cdb_valid_i  (cdbValid),
    .cdb_rob_i    (cdbROB),
    .cdb_result_i (cdbResult),
    .rob1_i       (rob1),
    .rob2_i       (rob2),
    .ready1_o     (ready1),
    .ready2_o     (ready2),
    .value1_o     (value1),
    .value2_o     (value2)
  );

  assign allocROB    = tail_q;
  assign fullRob     = w_full;
  assign validCommit = valid_commit_q;
  assign commitInfo  = commit_info_q;
  assign commitROB   = commit_rob_q;
  assign result      = result_q;
  assign regStatusC  = reg_status_q;
  assign controlFlow = ctrl_flow_q;
  assign redirectPC  = redirect_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rob_commit                                                    |
// | Self-checking bench: directed scenarios plus random traffic      |
// | compared against a queue-based reference model.                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_rob_commit;
  import rob_pkg::*;

  localparam int WIDTH = 31;
  localparam int REG   = 4;
  localparam int ROB   = 2;
`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, allocReq, allocRegWrite, allocBranch;
  logic [REG:0] allocDestReg;
  logic [WIDTH:0] allocStatusSnap;
  logic [ROB:0] allocROB;
  logic fullRob, cdbValid, cdbMispredict;
  logic [ROB:0] cdbROB, rob1, rob2;
  logic [WIDTH:0] cdbResult, cdbTarget, value1, value2;
  logic ready1, ready2, validCommit;
  logic [WIDTH+5:0] commitInfo;
  logic [ROB:0] commitROB;
  logic [WIDTH:0] result, regStatusC, redirectPC;
  logic [1:0] controlFlow;

  rob_commit #(.WIDTH(WIDTH), .REG(REG), .ROB(ROB)) dut (
    .clk(clk), .reset(reset), .allocReq(allocReq), .allocRegWrite(allocRegWrite),
    .allocBranch(allocBranch), .allocDestReg(allocDestReg), .allocStatusSnap(allocStatusSnap),
    .allocROB(allocROB), .fullRob(fullRob), .cdbValid(cdbValid), .cdbROB(cdbROB),
    .cdbResult(cdbResult), .cdbTarget(cdbTarget), .cdbMispredict(cdbMispredict),
    .rob1(rob1), .rob2(rob2), .ready1(ready1), .ready2(ready2), .value1(value1),
    .value2(value2), .validCommit(validCommit), .commitInfo(commitInfo),
    .commitROB(commitROB), .result(result), .regStatusC(regStatusC),
    .controlFlow(controlFlow), .redirectPC(redirectPC)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight tags held oldest-first in a queue
  int          q[$];
  bit          m_done [ROB_DEPTH];
  bit          m_rw   [ROB_DEPTH];
  bit          m_br   [ROB_DEPTH];
  bit          m_misp [ROB_DEPTH];
  logic [4:0]  m_dest [ROB_DEPTH];
  logic [31:0] m_val  [ROB_DEPTH];
  logic [31:0] m_tgt  [ROB_DEPTH];
  logic [31:0] m_snap [ROB_DEPTH];
  int          m_tail;
  bit          m_flush;
  logic        e_valid;
  logic [36:0] e_info;
  logic [2:0]  e_rob;
  logic [1:0]  e_cf;
  logic [31:0] e_result, e_redir, e_stat;

  task automatic model_reset();
    q.delete();
    m_tail = 0; m_flush = 0;
    e_valid = 0; e_info = '0; e_rob = '0; e_cf = 2'b00;
    e_result = '0; e_redir = '0; e_stat = '0;
  endtask

  function automatic bit in_q(int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_rdy(logic [2:0] t);
    if (BYP && cdbValid && cdbROB == t) return 1'b1;
    return in_q(int'(t)) && m_done[t];
  endfunction

  function automatic logic [31:0] exp_val(logic [2:0] t);
    if (BYP && cdbValid && cdbROB == t) return cdbResult;
    return m_val[t];
  endfunction

  // Advance the model across one clock edge using the inputs present at that edge
  task automatic model_edge();
    int  h;
    int  pre;
    bit  commit;
    e_valid = 0; e_info = '0; e_rob = '0; e_result = '0; e_cf = 2'b00;
    if (m_flush) begin
      q.delete(); m_tail = 0; m_flush = 0; e_cf = 2'b11;
      return;
    end
    pre = q.size();
    commit = (pre > 0) && m_done[q[0]];
    if (commit) begin
      h = q[0];
      e_valid = 1'b1;
      e_info = {1'b0, m_rw[h], 30'b0, m_dest[h]};
      e_rob = 3'(h);
      e_result = m_val[h];
      if (m_br[h] && m_misp[h]) begin
        m_flush = 1'b1; e_redir = m_tgt[h]; e_stat = m_snap[h];
      end
    end
    if (cdbValid && in_q(int'(cdbROB))) begin
      m_done[cdbROB] = 1'b1; m_val[cdbROB] = cdbResult;
      m_tgt[cdbROB] = cdbTarget; m_misp[cdbROB] = cdbMispredict;
    end
    if (commit) void'(q.pop_front());
    if (allocReq && pre < ROB_DEPTH) begin
      m_done[m_tail] = 0; m_misp[m_tail] = 0; m_rw[m_tail] = allocRegWrite;
      m_br[m_tail] = allocBranch; m_dest[m_tail] = allocDestReg; m_snap[m_tail] = allocStatusSnap;
      q.push_back(m_tail);
      m_tail = (m_tail + 1) % ROB_DEPTH;
    end
  endtask

  // One clock: combinational outputs before the edge, registered ones after
  task automatic step();
    #1;
    checks++; if (allocROB !== 3'(m_tail)) begin errors++; $display("FAIL allocROB: got %0d expected %0d", allocROB, m_tail); end
    checks++; if (fullRob !== (q.size() == ROB_DEPTH)) begin errors++; $display("FAIL fullRob: got %0b expected %0b", fullRob, q.size() == ROB_DEPTH); end
    checks++; if (ready1 !== exp_rdy(rob1)) begin errors++; $display("FAIL ready1 tag %0d: got %0b expected %0b", rob1, ready1, exp_rdy(rob1)); end
    if (exp_rdy(rob1)) begin
      checks++; if (value1 !== exp_val(rob1)) begin errors++; $display("FAIL value1: got %h expected %h", value1, exp_val(rob1)); end
    end
    checks++; if (ready2 !== exp_rdy(rob2)) begin errors++; $display("FAIL ready2 tag %0d: got %0b expected %0b", rob2, ready2, exp_rdy(rob2)); end
    if (exp_rdy(rob2)) begin
      checks++; if (value2 !== exp_val(rob2)) begin errors++; $display("FAIL value2: got %h expected %h", value2, exp_val(rob2)); end
    end
    @(posedge clk);
    model_edge();
    #1;
    checks++; if (validCommit !== e_valid) begin errors++; $display("FAIL validCommit: got %0b expected %0b", validCommit, e_valid); end
    checks++; if (commitInfo !== e_info) begin errors++; $display("FAIL commitInfo: got %h expected %h", commitInfo, e_info); end
    checks++; if (commitROB !== e_rob) begin errors++; $display("FAIL commitROB: got %0d expected %0d", commitROB, e_rob); end
    checks++; if (result !== e_result) begin errors++; $display("FAIL result: got %h expected %h", result, e_result); end
    checks++; if (controlFlow !== e_cf) begin errors++; $display("FAIL controlFlow: got %b expected %b", controlFlow, e_cf); end
    checks++; if (redirectPC !== e_redir) begin errors++; $display("FAIL redirectPC: got %h expected %h", redirectPC, e_redir); end
    checks++; if (regStatusC !== e_stat) begin errors++; $display("FAIL regStatusC: got %h expected %h", regStatusC, e_stat); end
  endtask

  task automatic idle();
    allocReq = 0; allocRegWrite = 0; allocBranch = 0; allocDestReg = '0; allocStatusSnap = '0;
    cdbValid = 0; cdbROB = '0; cdbResult = '0; cdbTarget = '0; cdbMispredict = 0;
    rob1 = '0; rob2 = '0;
  endtask

  task automatic alloc(bit rw, logic [4:0] d, bit br, logic [31:0] s);
    idle(); allocReq = 1; allocRegWrite = rw; allocDestReg = d; allocBranch = br; allocStatusSnap = s;
    step();
  endtask

  task automatic cdb(logic [2:0] t, logic [31:0] v, bit mp, logic [31:0] tg);
    idle(); cdbValid = 1; cdbROB = t; cdbResult = v; cdbMispredict = mp; cdbTarget = tg;
    step();
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({validCommit, commitInfo, commitROB, result} !== '0) begin errors++; $display("FAIL reset_commit: got %b/%h expected 0", validCommit, commitInfo); end
    checks++; if ({controlFlow, redirectPC, regStatusC} !== '0) begin errors++; $display("FAIL reset_flush: got %b/%h/%h expected 0", controlFlow, redirectPC, regStatusC); end
    checks++; if ({allocROB, fullRob, ready1, ready2} !== '0) begin errors++; $display("FAIL reset_ptr: got %0d/%0b expected 0/0", allocROB, fullRob); end
    reset = 0;
    model_reset();
  endtask

  task automatic test_fill();
    test_reset();
    for (int i = 0; i < 8; i++) begin
      checks++; if (allocROB !== 3'(i)) begin errors++; $display("FAIL fill_tag: got %0d expected %0d", allocROB, i); end
      alloc(1'b1, 5'(i), 1'b0, 32'h0);
    end
    idle(); allocReq = 1;
    checks++; if (fullRob !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", fullRob); end
    step();
    checks++; if (allocROB !== 3'd0) begin errors++; $display("FAIL fill_ninth_tail: got %0d expected 0", allocROB); end
  endtask

  task automatic test_completion();
    test_reset();
    alloc(1'b1, 5'd5, 1'b0, 32'h0);
    cdb(3'd0, 32'h55, 1'b0, 32'h0);
    checks++; if (validCommit !== 1'b0) begin errors++; $display("FAIL compl_early: got %0b expected 0", validCommit); end
    idle(); step();
    checks++; if (validCommit !== 1'b1 || commitInfo[4:0] !== 5'd5 || commitInfo[WIDTH+4] !== 1'b1)
      begin errors++; $display("FAIL compl_info: got %0b/%h expected 1/rd5,rw1", validCommit, commitInfo); end
    checks++; if (result !== 32'h55) begin errors++; $display("FAIL compl_result: got %h expected 55", result); end
    idle(); step();
    checks++; if (validCommit !== 1'b0) begin errors++; $display("FAIL compl_pulse: got %0b expected 0", validCommit); end
  endtask

  task automatic test_ordering();
    test_reset();
    alloc(1'b1, 5'd1, 1'b0, 32'h0);
    alloc(1'b1, 5'd2, 1'b0, 32'h0);
    cdb(3'd1, 32'h11, 1'b0, 32'h0);
    idle(); step();
    checks++; if (validCommit !== 1'b0) begin errors++; $display("FAIL order_wait: got %0b expected 0", validCommit); end
    cdb(3'd0, 32'h10, 1'b0, 32'h0);
    idle(); step();
    checks++; if (validCommit !== 1'b1 || commitROB !== 3'd0) begin errors++; $display("FAIL order_first: got %0b/%0d expected 1/0", validCommit, commitROB); end
    step();
    checks++; if (validCommit !== 1'b1 || commitROB !== 3'd1) begin errors++; $display("FAIL order_second: got %0b/%0d expected 1/1", validCommit, commitROB); end
  endtask

  task automatic test_mispredict();
    test_reset();
    alloc(1'b1, 5'd1, 1'b0, 32'h0);
    alloc(1'b1, 5'd2, 1'b0, 32'h0);
    alloc(1'b1, 5'd1, 1'b1, 32'h0000_00F0);
    alloc(1'b1, 5'd3, 1'b0, 32'h0);
    cdb(3'd0, 32'h1, 1'b0, 32'h0);
    cdb(3'd1, 32'h2, 1'b0, 32'h0);
    cdb(3'd2, 32'h2C, 1'b1, 32'h100);
    cdb(3'd3, 32'h3, 1'b0, 32'h0);
    checks++; if (validCommit !== 1'b1 || commitROB !== 3'd2 || commitInfo[WIDTH+4] !== 1'b1)
      begin errors++; $display("FAIL misp_commit: got %0b/%0d expected 1/2", validCommit, commitROB); end
    idle(); step();
    checks++; if (controlFlow !== 2'b11 || redirectPC !== 32'h100 || regStatusC !== 32'hF0)
      begin errors++; $display("FAIL misp_flush: got %b/%h/%h expected 11/100/f0", controlFlow, redirectPC, regStatusC); end
    checks++; if (allocROB !== 3'd0 || fullRob !== 1'b0) begin errors++; $display("FAIL misp_empty: got %0d/%0b expected 0/0", allocROB, fullRob); end
    idle(); step();
    checks++; if (controlFlow !== 2'b00 || validCommit !== 1'b0) begin errors++; $display("FAIL misp_after: got %b/%0b expected 00/0", controlFlow, validCommit); end
  endtask

  task automatic test_reset_mid_flush();
    test_reset();
    alloc(1'b1, 5'd1, 1'b1, 32'h3);
    cdb(3'd0, 32'h1, 1'b1, 32'h200);
    idle(); step();
    checks++; if (validCommit !== 1'b1) begin errors++; $display("FAIL rmf_commit: got %0b expected 1", validCommit); end
    reset = 1;
    @(posedge clk); #1;
    checks++; if (controlFlow !== 2'b00 || redirectPC !== '0 || validCommit !== 1'b0)
      begin errors++; $display("FAIL rmf_reset: got %b/%h expected 00/0", controlFlow, redirectPC); end
    reset = 0;
    model_reset();
  endtask

  task automatic test_simultaneous();
    test_reset();
    for (int i = 0; i < 4; i++) alloc(1'b0, 5'(i), 1'b0, 32'h0);
    cdb(3'd0, 32'h7, 1'b0, 32'h0);
    alloc(1'b1, 5'd9, 1'b0, 32'h0);
    checks++; if (validCommit !== 1'b1 || commitROB !== 3'd0 || allocROB !== 3'd5)
      begin errors++; $display("FAIL simul: got %0b/%0d/%0d expected 1/0/5", validCommit, commitROB, allocROB); end
    for (int i = 0; i < 3; i++) alloc(1'b0, 5'd0, 1'b0, 32'h0);
    checks++; if (fullRob !== 1'b0 || allocROB !== 3'd0) begin errors++; $display("FAIL simul_seven: got %0b/%0d expected 0/0", fullRob, allocROB); end
    alloc(1'b0, 5'd0, 1'b0, 32'h0);
    checks++; if (fullRob !== 1'b1) begin errors++; $display("FAIL simul_full: got %0b expected 1", fullRob); end
  endtask

  task automatic test_bypass();
    test_reset();
    for (int i = 0; i < 4; i++) alloc(1'b0, 5'(i), 1'b0, 32'h0);
    idle(); cdbValid = 1; cdbROB = 3'd3; cdbResult = 32'hAB; rob1 = 3'd3;
    #1;
    checks++; if (ready1 !== BYP) begin errors++; $display("FAIL bypass_ready: got %0b expected %0b", ready1, BYP); end
`ifdef ROB_CDB_BYPASS_EN
    checks++; if (value1 !== 32'hAB) begin errors++; $display("FAIL bypass_value: got %h expected ab", value1); end
`endif
    step();
    idle(); rob1 = 3'd3;
    #1;
    checks++; if (ready1 !== 1'b1 || value1 !== 32'hAB) begin errors++; $display("FAIL bypass_stored: got %0b/%h expected 1/ab", ready1, value1); end
    step();
  endtask

  task automatic test_random();
    int idx;
    test_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      allocReq = ($urandom % 3) != 0;
      allocRegWrite = $urandom % 2;
      allocBranch = ($urandom % 4) == 0;
      allocDestReg = 5'($urandom);
      allocStatusSnap = $urandom;
      if (q.size() > 0 && ($urandom % 4) != 0) begin
        idx = $urandom_range(0, q.size() - 1);
        cdbValid = 1; cdbROB = 3'(q[idx]);
      end else begin
        cdbValid = ($urandom % 4) == 0; cdbROB = 3'($urandom);
      end
      cdbResult = $urandom; cdbTarget = $urandom;
      cdbMispredict = ($urandom % 5) == 0;
      rob1 = 3'($urandom);
      rob2 = (q.size() > 0) ? 3'(q[$urandom_range(0, q.size() - 1)]) : 3'($urandom);
      step();
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_fill();
    test_completion();
    test_ordering();
    test_mispredict();
    test_reset_mid_flush();
    test_simultaneous();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
